// File: rtl/dac7611_arbiter_if.sv
// Request/grant bundle and DAC7611 pin group shared by dac7611_arbiter and its client.
interface dac7611_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*12-1:0] data;
    logic [NREQ-1:0]    gnt;
    logic               clr_req;
    logic               busy;
    logic               done;
    logic [2:0]         done_id;
    logic               dac_cs_n;
    logic               dac_clk;
    logic               dac_sdi;
    logic               dac_ld_n;
    logic               dac_clr_n;

    modport master (
        output req, data, clr_req,
        input  gnt, busy, done, done_id,
        input  dac_cs_n, dac_clk, dac_sdi, dac_ld_n, dac_clr_n
    );

    modport slave (
        input  req, data, clr_req,
        output gnt, busy, done, done_id,
        output dac_cs_n, dac_clk, dac_sdi, dac_ld_n, dac_clr_n
    );
endinterface

// File: rtl/dac7611_arbiter.sv
// Round-robin arbiter sharing one DAC7611 serial DAC among NREQ requesters.
// Define DAC7611_CLR_EN to build the clr_req / CLEAR pulse support.
module dac7611_arbiter #(
    parameter int NREQ    = 4,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    dac7611_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int SW = IW + 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

`ifdef DAC7611_CLR_EN
    typedef enum logic [2:0] {IDLE, SHIFT, CSHI, LOAD, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, CSHI, LOAD} state_t;
`endif

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [3:0]      bit_idx, bit_d;
    logic [11:0]     shreg, shreg_d;
    logic [IW-1:0]   ptr, ptr_d;
    logic [2:0]      cur, cur_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [2:0]      done_id_q, done_id_d;
    logic            cs_n_q, cs_n_d;
    logic            dclk_q, dclk_d;
    logic            sdi_q, sdi_d;
    logic            ld_n_q, ld_n_d;

    logic [11:0]     codes [NREQ];
    logic            found;
    logic [IW-1:0]   sel;
    logic [SW-1:0]   rr_sum;
    logic [SW-1:0]   ptr_inc;

`ifdef DAC7611_CLR_EN
    logic            clr_pend, clr_pend_d;
    logic            clr_n_q, clr_n_d;
`else
    logic            unused_clr_req;
    assign unused_clr_req = bus.clr_req;
`endif

    always_comb begin
        for (int i = 0; i < NREQ; i++) codes[i] = bus.data[12*i +: 12];
    end

    // First set request at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        found  = 1'b0;
        sel    = '0;
        rr_sum = '0;
        for (int k = 0; k < NREQ; k++) begin
            rr_sum = {1'b0, ptr} + SW'(k);
            if (rr_sum >= SW'(NREQ)) rr_sum = rr_sum - SW'(NREQ);
            if (!found && bus.req[rr_sum[IW-1:0]]) begin
                found = 1'b1;
                sel   = rr_sum[IW-1:0];
            end
        end
        ptr_inc = {1'b0, sel} + SW'(1);
        if (ptr_inc == SW'(NREQ)) ptr_inc = '0;
    end

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_d   = state;
        cnt_d     = cnt;
        bit_d     = bit_idx;
        shreg_d   = shreg;
        ptr_d     = ptr;
        cur_d     = cur;
        gnt_d     = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        cs_n_d    = cs_n_q;
        dclk_d    = dclk_q;
        sdi_d     = sdi_q;
        ld_n_d    = ld_n_q;
`ifdef DAC7611_CLR_EN
        clr_pend_d = clr_pend | bus.clr_req;
        clr_n_d    = clr_n_q;
`endif
        unique case (state)
            IDLE: begin
`ifdef DAC7611_CLR_EN
                if (clr_pend) begin
                    clr_n_d = 1'b0;
                    cnt_d   = '0;
                    state_d = CLEAR;
                end else
`endif
                if (found) begin
                    gnt_d[sel] = 1'b1;
                    shreg_d    = codes[sel];
                    sdi_d      = codes[sel][11];
                    cs_n_d     = 1'b0;
                    dclk_d     = 1'b0;
                    bit_d      = 4'd11;
                    cnt_d      = '0;
                    cur_d      = 3'(sel);
                    ptr_d      = ptr_inc[IW-1:0];
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    cnt_d = '0;
                    if (!dclk_q) begin
                        dclk_d = 1'b1;
                    end else if (bit_idx == 4'd0) begin
                        cs_n_d  = 1'b1;
                        state_d = CSHI;
                    end else begin
                        // Data only moves on the falling edge so it is stable at the DAC's rising edge.
                        dclk_d  = 1'b0;
                        bit_d   = bit_idx - 4'd1;
                        sdi_d   = shreg[10];
                        shreg_d = {shreg[10:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            CSHI: begin
                if (cnt == LAST) begin
                    cnt_d   = '0;
                    ld_n_d  = 1'b0;
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            LOAD: begin
                if (cnt == LAST) begin
                    cnt_d     = '0;
                    ld_n_d    = 1'b1;
                    done_d    = 1'b1;
                    done_id_d = cur;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
`ifdef DAC7611_CLR_EN
            CLEAR: begin
                if (cnt == LAST) begin
                    cnt_d      = '0;
                    clr_n_d    = 1'b1;
                    clr_pend_d = bus.clr_req;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            cur       <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            cs_n_q    <= 1'b1;
            dclk_q    <= 1'b1;
            sdi_q     <= 1'b0;
            ld_n_q    <= 1'b1;
`ifdef DAC7611_CLR_EN
            clr_pend  <= 1'b0;
            clr_n_q   <= 1'b1;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_d;
            cnt       <= cnt_d;
            bit_idx   <= bit_d;
            shreg     <= shreg_d;
            ptr       <= ptr_d;
            cur       <= cur_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            cs_n_q    <= cs_n_d;
            dclk_q    <= dclk_d;
            sdi_q     <= sdi_d;
            ld_n_q    <= ld_n_d;
`ifdef DAC7611_CLR_EN
            clr_pend  <= clr_pend_d;
            clr_n_q   <= clr_n_d;
`endif
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.done_id  = done_id_q;
    assign bus.dac_cs_n = cs_n_q;
    assign bus.dac_clk  = dclk_q;
    assign bus.dac_sdi  = sdi_q;
    assign bus.dac_ld_n = ld_n_q;
`ifdef DAC7611_CLR_EN
    assign bus.dac_clr_n = clr_n_q;
`else
    assign bus.dac_clr_n = 1'b1;
`endif
endmodule

// File: tb/tb_dac7611_arbiter.sv
// Scoreboard bench for dac7611_arbiter: a round-robin model predicts frames/clears, a pin monitor decodes them.
module tb_dac7611_arbiter;
    localparam int NREQ = 4;
    localparam int D    = 2;

    typedef struct {
        bit          is_clr;
        int          id;
        logic [11:0] code;
        bit          chk_gap;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dac7611_arbiter_if #(.NREQ(NREQ)) bus ();
    dac7611_arbiter #(.NREQ(NREQ), .CLK_DIV(D)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    exp_t        exp_q [$];
    logic [11:0] codes_q [NREQ][$];
    logic [11:0] plan_codes [NREQ][$];
    logic [NREQ-1:0] glitch = '0;
    int          mptr = 0;

    int          t = 0;
    int          frames_started = 0;
    int          nbits = 0;
    bit          in_frame = 0;
    bit          in_clr = 0;

    task automatic check(input bit ok, input string name, input int act, input int expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0d)", name, act, expv, t);
        end
    endtask

    // Requester driver: each requester holds req while it has codes queued; a grant consumes one.
    initial begin : driver
        logic [NREQ-1:0]    r;
        logic [NREQ*12-1:0] d;
        bus.req = '0;
        bus.data = '0;
        bus.clr_req = 1'b0;
        forever begin
            @(negedge clk);
            r = '0;
            d = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (reset && bus.gnt[i] && codes_q[i].size() > 0) void'(codes_q[i].pop_front());
                r[i] = (codes_q[i].size() > 0) | glitch[i];
                if (codes_q[i].size() > 0) d[12*i +: 12] = codes_q[i][0];
            end
            bus.req  = r;
            bus.data = d;
        end
    end

    // Pin monitor: decodes frames and clear pulses and compares each against the scoreboard head.
    initial begin : monitor
        exp_t        cur;
        logic [11:0] bits;
        logic [NREQ-1:0] oh;
        int start_t, cs_rise_t, ld_fall_t, clr_fall_t, last_end;
        bit p_cs, p_dclk, p_sdi, p_ld, p_clr;
        bit cs_fall, cs_rise, dclk_rise, dclk_fall, ld_fall, ld_rise, clr_fall, clr_rise;
        p_cs = 1; p_dclk = 1; p_sdi = 0; p_ld = 1; p_clr = 1;
        start_t = 0; cs_rise_t = 0; ld_fall_t = 0; clr_fall_t = 0; last_end = -100;
        bits = '0;
        cur = '{0, 0, 12'h0, 0};
        forever begin
            @(negedge clk);
            t++;
            if (!reset) begin
                in_frame = 0; in_clr = 0; nbits = 0;
                p_cs = 1; p_dclk = 1; p_sdi = 0; p_ld = 1; p_clr = 1;
            end else begin
                cs_fall   = p_cs && !bus.dac_cs_n;
                cs_rise   = !p_cs && bus.dac_cs_n;
                dclk_rise = !p_dclk && bus.dac_clk;
                dclk_fall = p_dclk && !bus.dac_clk;
                ld_fall   = p_ld && !bus.dac_ld_n;
                ld_rise   = !p_ld && bus.dac_ld_n;
                clr_fall  = p_clr && !bus.dac_clr_n;
                clr_rise  = !p_clr && bus.dac_clr_n;

                if (cs_fall) begin
                    frames_started++;
                    if (exp_q.size() == 0) begin
                        check(0, "unexpected_frame", int'(bus.gnt), 0);
                    end else begin
                        cur = exp_q.pop_front();
                        check(!cur.is_clr, "clear_expected_got_frame", 0, 1);
                        oh = '0;
                        oh[cur.id] = 1'b1;
                        check(bus.gnt == oh, "gnt_onehot", int'(bus.gnt), int'(oh));
                        check(bus.busy, "busy_in_frame", int'(bus.busy), 1);
                        if (cur.chk_gap) check(t - last_end == 1, "start_gap", t - last_end, 1);
                    end
                    in_frame = 1; start_t = t; nbits = 0; bits = '0;
                end else if (bus.gnt != '0) begin
                    check(0, "gnt_stray", int'(bus.gnt), 0);
                end

                if (dclk_rise && !bus.dac_cs_n) begin
                    bits = {bits[10:0], bus.dac_sdi};
                    nbits++;
                end
                if (bus.dac_sdi != p_sdi && !dclk_fall) check(0, "sdi_moved_off_fall", int'(bus.dac_sdi), int'(p_sdi));

                if (cs_rise) begin
                    cs_rise_t = t;
                    check(t - start_t == 24*D, "cs_low_len", t - start_t, 24*D);
                    check(nbits == 12 && bits == cur.code, "sdi_code", int'(bits), int'(cur.code));
                    check(bus.dac_clk, "dclk_idle_high", int'(bus.dac_clk), 1);
                end
                if (ld_fall) begin
                    ld_fall_t = t;
                    check(in_frame && t - cs_rise_t == D, "cs_to_ld", t - cs_rise_t, D);
                end
                if (ld_rise) begin
                    check(t - ld_fall_t == D, "ld_low_len", t - ld_fall_t, D);
                    check(t - start_t == 26*D, "frame_len", t - start_t, 26*D);
                    check(bus.done && bus.done_id == 3'(cur.id), "done_id", int'({bus.done, bus.done_id}), 8 + cur.id);
                    check(!bus.busy, "busy_after_frame", int'(bus.busy), 0);
                    last_end = t;
                    in_frame = 0;
                end else if (bus.done) begin
                    check(0, "done_stray", int'(bus.done), 0);
                end

                if (clr_fall) begin
                    if (exp_q.size() == 0) begin
                        check(0, "unexpected_clear", 0, 1);
                    end else begin
                        cur = exp_q.pop_front();
                        check(cur.is_clr, "frame_expected_got_clear", int'(cur.is_clr), 1);
                        if (cur.chk_gap) check(t - last_end == 1, "clear_gap", t - last_end, 1);
                    end
                    in_clr = 1; clr_fall_t = t;
                end
                if (clr_rise) begin
                    check(t - clr_fall_t == D, "clr_low_len", t - clr_fall_t, D);
                    last_end = t;
                    in_clr = 0;
                end

                p_cs = bus.dac_cs_n; p_dclk = bus.dac_clk; p_sdi = bus.dac_sdi;
                p_ld = bus.dac_ld_n; p_clr = bus.dac_clr_n;
            end
        end
    end

    task automatic wait_started(input int target, input int budget);
        int n = 0;
        while (frames_started < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (frames_started < target) check(0, "wait_frame_timeout", frames_started, target);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || in_frame || in_clr) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || in_frame || in_clr) begin
            check(0, "drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_clr();
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
    endtask

    // Model: round-robin over requesters with queued codes; a clear follows the frame it was raised in.
    task automatic issue_batch(input int clr_id, input bit glitch_en);
        int   k [NREQ];
        int   total, base, id, clr_idx, gidle, j;
        exp_t e;
        total = 0; clr_idx = -1; gidle = -1;
        for (int i = 0; i < NREQ; i++) begin
            k[i] = 0;
            total += plan_codes[i].size();
            if (plan_codes[i].size() == 0) gidle = i;
        end
        for (int n = 0; n < total; n++) begin
            id = -1;
            for (int off = 0; off < NREQ && id < 0; off++) begin
                j = (mptr + off) % NREQ;
                if (k[j] < plan_codes[j].size()) id = j;
            end
            e.is_clr = 0; e.id = id; e.code = plan_codes[id][k[id]]; e.chk_gap = (n > 0);
            exp_q.push_back(e);
            k[id]++;
            mptr = (id + 1) % NREQ;
            if (id == clr_id && clr_idx < 0) begin
                clr_idx = n;
`ifdef DAC7611_CLR_EN
                e.is_clr = 1; e.chk_gap = 1;
                exp_q.push_back(e);
`endif
            end
        end
        base = frames_started;
        for (int i = 0; i < NREQ; i++) begin
            codes_q[i] = plan_codes[i];
            plan_codes[i].delete();
        end
        if (glitch_en && gidle >= 0) begin
            wait_started(base + 1, 200);
            repeat (4) @(negedge clk);
            glitch[gidle] = 1'b1;
            repeat (3) @(negedge clk);
            glitch[gidle] = 1'b0;
        end
        if (clr_idx >= 0) begin
            wait_started(base + clr_idx + 1, 100 * total + 100);
            repeat (3) @(negedge clk);
            pulse_clr();
            repeat (4) @(negedge clk);
            pulse_clr();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check(bus.gnt == '0 && !bus.busy && !bus.done && bus.done_id == 3'd0, {tag, "_ctrl"},
              int'({bus.gnt, bus.busy, bus.done, bus.done_id}), 0);
        check({bus.dac_cs_n, bus.dac_clk, bus.dac_sdi, bus.dac_ld_n, bus.dac_clr_n} == 5'b11011, {tag, "_pins"},
              int'({bus.dac_cs_n, bus.dac_clk, bus.dac_sdi, bus.dac_ld_n, bus.dac_clr_n}), 'h1b);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int   b, n, cid;
        exp_t e;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single request, known code.
        plan_codes[0].push_back(12'hA5C);
        issue_batch(-1, 0);
        wait_drain(300);

        // All four held, two frames each.
        for (int i = 0; i < NREQ; i++) repeat (2) plan_codes[i].push_back(12'($urandom));
        issue_batch(-1, 0);
        wait_drain(1000);

        // Requester 2 dropped.
        for (int i = 0; i < NREQ; i++) if (i != 2) repeat (2) plan_codes[i].push_back(12'($urandom));
        issue_batch(-1, 1);
        wait_drain(1000);

        // All-ones then all-zeros codes.
        plan_codes[1].push_back(12'hFFF);
        plan_codes[1].push_back(12'h000);
        issue_batch(-1, 0);
        wait_drain(400);

        // Double clr_req during requester 1's frame with requester 3 waiting.
        plan_codes[1].push_back(12'($urandom));
        plan_codes[3].push_back(12'($urandom));
        issue_batch(1, 0);
        wait_drain(400);

        // Clear requested from idle.
`ifdef DAC7611_CLR_EN
        e.is_clr = 1; e.id = 0; e.code = '0; e.chk_gap = 0;
        exp_q.push_back(e);
`endif
        pulse_clr();
        wait_drain(100);
        repeat (10) @(negedge clk);

        // Randomised batches.
        for (int r = 0; r < 8; r++) begin
            n = 0;
            for (int i = 0; i < NREQ; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    plan_codes[i].push_back(12'($urandom));
                    n++;
                end
            end
            if (n == 0) plan_codes[$urandom_range(0, NREQ-1)].push_back(12'($urandom));
            cid = -1;
            if ($urandom_range(0, 1) == 1)
                for (int i = 0; i < NREQ; i++) if (cid < 0 && plan_codes[i].size() > 0) cid = i;
            issue_batch(cid, 1'($urandom_range(0, 1)));
            wait_drain(1500);
        end

        // Reset in the middle of requester 2's frame (during bit 5).
        b = frames_started;
        plan_codes[2].push_back(12'($urandom));
        issue_batch(-1, 0);
        wait_started(b + 1, 200);
        n = 0;
        while (nbits < 7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (nbits < 7) check(0, "bit5_timeout", nbits, 7);
        #2 reset = 1'b0;
        #1 check_reset_vals("async_reset");
        for (int i = 0; i < NREQ; i++) codes_q[i].delete();
        exp_q.delete();
        mptr = 0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset");
        plan_codes[2].push_back(12'($urandom));
        plan_codes[3].push_back(12'($urandom));
        issue_batch(-1, 0);
        wait_drain(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
